// File: rtl/adr_gen_multi_if.sv
// Bus between the sequencer/OPR decode and the multi-channel address generator.
// The master issues pointer ops; the slave returns the memory address and channel status.
interface adr_gen_multi_if #(
   parameter int W   = 9,
   parameter int NCH = 4
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [2:0]     op;
   logic [CW-1:0]  ch_sel;
   logic [W-1:0]   din;
   logic [2*W-1:0] d_address;
   logic [NCH-1:0] z_flag;
   logic [NCH-1:0] wrap_flag;
   logic           busy;
   logic           win_done;

   modport master (
      output op, ch_sel, din,
      input  d_address, z_flag, wrap_flag, busy, win_done
   );

   modport slave (
      input  op, ch_sel, din,
      output d_address, z_flag, wrap_flag, busy, win_done
   );
endinterface

// File: rtl/adr_gen_multi.sv
// Multi-channel row/column pointer unit with raster stepping, image-bounded wrap
// and an autonomous 2x2 neighbourhood walk driving the data-memory address bus.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | accepting ops; address shows channel ch_sel
//  ST_W0   | walk address (r, c)
//  ST_W1   | walk address (r, c+1), column clamped
//  ST_W2   | walk address (r+1, c), row clamped
//  ST_W3   | walk address (r+1, c+1), both clamped
//  ST_DONE | win_done pulse; address shows latched channel; ops accepted
module adr_gen_multi #(
   parameter int W    = 9,
   parameter int NCH  = 4,
   parameter int ROWS = 256,
   parameter int COLS = 256,
   parameter int STEP = 1
) (
   input  logic             clock,
   input  logic             reset,
   adr_gen_multi_if.slave   bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LDR  = 3'd1;
   localparam logic [2:0] OP_LDC  = 3'd2;
   localparam logic [2:0] OP_INC  = 3'd3;
   localparam logic [2:0] OP_DEC  = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_INCN = 3'd6;
   localparam logic [2:0] OP_WIN  = 3'd7;

   localparam logic [W:0]   ROWS_L  = (W+1)'(ROWS);
   localparam logic [W:0]   COLS_L  = (W+1)'(COLS);
   localparam logic [W:0]   STEP_L  = (W+1)'(STEP);
   localparam logic [W-1:0] ROW_MAX = W'(ROWS - 1);
   localparam logic [W-1:0] COL_MAX = W'(COLS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W0,
      ST_W1,
      ST_W2,
      ST_W3,
      ST_DONE
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]   rows [NCH];
   logic [W-1:0]   cols [NCH];
   logic [NCH-1:0] wrap_q;

   logic [W-1:0]   base_r, base_c;
   logic [CW-1:0]  win_ch;

   logic [W-1:0]   sel_row, sel_col;
   logic           sel_wrap, sel_hit;
   logic [W-1:0]   win_row, win_col;

   logic [W-1:0]   nxt_row, nxt_col;
   logic           nxt_wrap;
   logic [W:0]     s_inc, sum;
   logic           accept, upd, start_win;
   logic [W-1:0]   r1, c1;

   always_comb begin
      sel_row  = '0;
      sel_col  = '0;
      sel_wrap = 1'b0;
      sel_hit  = 1'b0;
      win_row  = '0;
      win_col  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.ch_sel == CW'(i)) begin
            sel_row  = rows[i];
            sel_col  = cols[i];
            sel_wrap = wrap_q[i];
            sel_hit  = 1'b1;
         end
         if (win_ch == CW'(i)) begin
            win_row = rows[i];
            win_col = cols[i];
         end
      end
   end

   // DONE is the final cycle of a walk; the next op is taken at its closing edge.
   assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && sel_hit;
   assign start_win = accept && (bus.op == OP_WIN);
   assign upd       = accept && (bus.op != OP_NOP) && (bus.op != OP_WIN);

   always_comb begin
      nxt_row  = sel_row;
      nxt_col  = sel_col;
      nxt_wrap = sel_wrap;
      s_inc    = '0;
      sum      = '0;
      case (bus.op)
         OP_LDR: begin
            nxt_row  = ({1'b0, bus.din} >= ROWS_L) ? ROW_MAX : bus.din;
            nxt_wrap = 1'b0;
         end
         OP_LDC: begin
            nxt_col = ({1'b0, bus.din} >= COLS_L) ? COL_MAX : bus.din;
         end
         OP_INC, OP_INCN: begin
            if (bus.op == OP_INC)
               s_inc = STEP_L;
            else if ({1'b0, bus.din} >= COLS_L)
               s_inc = {1'b0, COL_MAX};
            else
               s_inc = {1'b0, bus.din};
            sum = {1'b0, sel_col} + s_inc;
            if (sum < COLS_L) begin
               nxt_col = sum[W-1:0];
            end else begin
               nxt_col = W'(sum - COLS_L);
               if (sel_row == ROW_MAX) begin
                  nxt_row  = '0;
                  nxt_wrap = 1'b1;
               end else begin
                  nxt_row = sel_row + 1'b1;
               end
            end
         end
         OP_DEC: begin
            if ({1'b0, sel_col} >= STEP_L) begin
               nxt_col = W'({1'b0, sel_col} - STEP_L);
            end else begin
               nxt_col = W'({1'b0, sel_col} + COLS_L - STEP_L);
               if (sel_row == '0) begin
                  nxt_row  = ROW_MAX;
                  nxt_wrap = 1'b1;
               end else begin
                  nxt_row = sel_row - 1'b1;
               end
            end
         end
         OP_CLR: begin
            nxt_row  = '0;
            nxt_col  = '0;
            nxt_wrap = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            rows[i] <= '0;
            cols[i] <= '0;
         end
         wrap_q <= '0;
      end else if (upd) begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.ch_sel == CW'(i)) begin
               rows[i]   <= nxt_row;
               cols[i]   <= nxt_col;
               wrap_q[i] <= nxt_wrap;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ST_IDLE;
         base_r <= '0;
         base_c <= '0;
         win_ch <= '0;
      end else begin
         state <= state_nxt;
         if (start_win) begin
            base_r <= sel_row;
            base_c <= sel_col;
            win_ch <= bus.ch_sel;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = start_win ? ST_W0 : ST_IDLE;
         ST_W0:   state_nxt = ST_W1;
         ST_W1:   state_nxt = ST_W2;
         ST_W2:   state_nxt = ST_W3;
         ST_W3:   state_nxt = ST_DONE;
         ST_DONE: state_nxt = start_win ? ST_W0 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Neighbourhood edges clamp to the last row/column instead of wrapping.
   assign r1 = (base_r == ROW_MAX) ? base_r : base_r + 1'b1;
   assign c1 = (base_c == COL_MAX) ? base_c : base_c + 1'b1;

   always_comb begin
      bus.d_address = {sel_row, sel_col};
      case (state)
         ST_W0:   bus.d_address = {base_r, base_c};
         ST_W1:   bus.d_address = {base_r, c1};
         ST_W2:   bus.d_address = {r1, base_c};
         ST_W3:   bus.d_address = {r1, c1};
         ST_DONE: bus.d_address = {win_row, win_col};
         default: ;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NCH; i++)
         bus.z_flag[i] = (rows[i] == '0) && (cols[i] == '0);
   end

   assign bus.wrap_flag = wrap_q;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.win_done  = (state == ST_DONE);

endmodule

// File: tb/tb_adr_gen_multi.sv
// Bench for adr_gen_multi: a 4-channel STEP=1 instance and an 8-channel STEP=3 instance,
// vector tables plus hand-written window-walk and reset-abort sequences.
module tb_adr_gen_multi;
   localparam int W = 9;

   localparam logic [2:0] NOP  = 3'd0;
   localparam logic [2:0] LDR  = 3'd1;
   localparam logic [2:0] LDC  = 3'd2;
   localparam logic [2:0] INC  = 3'd3;
   localparam logic [2:0] DEC  = 3'd4;
   localparam logic [2:0] CLR  = 3'd5;
   localparam logic [2:0] INCN = 3'd6;
   localparam logic [2:0] WIN  = 3'd7;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   adr_gen_multi_if #(.W(W), .NCH(4)) bus_a ();
   adr_gen_multi_if #(.W(W), .NCH(8)) bus_b ();

   adr_gen_multi #(.W(W), .NCH(4), .ROWS(256), .COLS(256), .STEP(1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   adr_gen_multi #(.W(W), .NCH(8), .ROWS(256), .COLS(256), .STEP(3)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   typedef struct {
      bit          b;
      logic [2:0]  op;
      int          ch;
      int          din;
      logic [17:0] addr;
      logic [7:0]  z;
      logic [7:0]  wr;
   } vec_t;

   typedef struct {
      string       name;
      bit          b;
      logic [17:0] addr;
      logic [7:0]  z;
      logic [7:0]  wr;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   vec_t va[21];
   vec_t vb[8];

   task automatic apply(bit b, logic [2:0] op, int ch, int din);
      if (!b) begin
         bus_a.op     = op;
         bus_a.ch_sel = 2'(ch);
         bus_a.din    = 9'(din);
      end else begin
         bus_b.op     = op;
         bus_b.ch_sel = 3'(ch);
         bus_b.din    = 9'(din);
      end
   endtask

   task automatic push(string nm, bit b, logic [17:0] a, logic [7:0] z, logic [7:0] wr,
                       logic bz, logic dn);
      exp_t e;
      e.name = nm; e.b = b; e.addr = a; e.z = z; e.wr = wr; e.busy = bz; e.done = dn;
      sb.push_back(e);
   endtask

   task automatic check_next();
      exp_t        e;
      logic [17:0] a;
      logic [7:0]  z, wr;
      logic        bz, dn;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expected entry queued");
         return;
      end
      e = sb.pop_front();
      if (!e.b) begin
         a = bus_a.d_address; z = {4'b0, bus_a.z_flag}; wr = {4'b0, bus_a.wrap_flag};
         bz = bus_a.busy; dn = bus_a.win_done;
      end else begin
         a = bus_b.d_address; z = bus_b.z_flag; wr = bus_b.wrap_flag;
         bz = bus_b.busy; dn = bus_b.win_done;
      end
      if (a !== e.addr || z !== e.z || wr !== e.wr || bz !== e.busy || dn !== e.done) begin
         errors++;
         $display("FAIL %s: got addr={%0d,%0d} z=%b wrap=%b busy=%b done=%b, want addr={%0d,%0d} z=%b wrap=%b busy=%b done=%b",
                  e.name, a[17:9], a[8:0], z, wr, bz, dn,
                  e.addr[17:9], e.addr[8:0], e.z, e.wr, e.busy, e.done);
      end
   endtask

   task automatic run_vec(vec_t v, string nm);
      apply(v.b, v.op, v.ch, v.din);
      push(nm, v.b, v.addr, v.z, v.wr, 1'b0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check_next();
      apply(v.b, NOP, v.ch, 0);
   endtask

   // Walk on dut_a with INC/WIN noise during the busy cycles and ch_sel moved away.
   task automatic walk(string nm, int ch, logic [17:0] p0, logic [17:0] p1,
                       logic [17:0] p2, logic [17:0] p3, logic [7:0] z, logic [7:0] wr);
      apply(0, WIN, ch, 0);
      push({nm, "_w0"}, 0, p0, z, wr, 1, 0);
      push({nm, "_w1"}, 0, p1, z, wr, 1, 0);
      push({nm, "_w2"}, 0, p2, z, wr, 1, 0);
      push({nm, "_w3"}, 0, p3, z, wr, 1, 0);
      push({nm, "_done"}, 0, p0, z, wr, 1, 1);
      push({nm, "_idle"}, 0, p0, z, wr, 0, 0);
      @(posedge clock);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check_next();
         case (i)
            0, 1:    apply(0, INC, 0, 0);
            2:       apply(0, WIN, 0, 0);
            3:       apply(0, NOP, 1, 0);
            default: apply(0, NOP, ch, 0);
         endcase
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      va[0]  = '{0, NOP,  2, 0,   {9'd0,   9'd0},   8'b1111, 8'b0000};
      va[1]  = '{0, LDR,  2, 5,   {9'd5,   9'd0},   8'b1011, 8'b0000};
      va[2]  = '{0, LDC,  2, 10,  {9'd5,   9'd10},  8'b1011, 8'b0000};
      va[3]  = '{0, INC,  2, 0,   {9'd5,   9'd11},  8'b1011, 8'b0000};
      va[4]  = '{0, NOP,  0, 0,   {9'd0,   9'd0},   8'b1011, 8'b0000};
      va[5]  = '{0, LDR,  0, 255, {9'd255, 9'd0},   8'b1010, 8'b0000};
      va[6]  = '{0, LDC,  0, 255, {9'd255, 9'd255}, 8'b1010, 8'b0000};
      va[7]  = '{0, INC,  0, 0,   {9'd0,   9'd0},   8'b1011, 8'b0001};
      va[8]  = '{0, DEC,  0, 0,   {9'd255, 9'd255}, 8'b1010, 8'b0001};
      va[9]  = '{0, CLR,  0, 0,   {9'd0,   9'd0},   8'b1011, 8'b0000};
      va[10] = '{0, LDC,  1, 250, {9'd0,   9'd250}, 8'b1001, 8'b0000};
      va[11] = '{0, INCN, 1, 10,  {9'd1,   9'd4},   8'b1001, 8'b0000};
      va[12] = '{0, INCN, 1, 0,   {9'd1,   9'd4},   8'b1001, 8'b0000};
      va[13] = '{0, LDC,  1, 300, {9'd1,   9'd255}, 8'b1001, 8'b0000};
      va[14] = '{0, INCN, 1, 400, {9'd2,   9'd254}, 8'b1001, 8'b0000};
      va[15] = '{0, DEC,  1, 0,   {9'd2,   9'd253}, 8'b1001, 8'b0000};
      va[16] = '{0, LDR,  1, 300, {9'd255, 9'd253}, 8'b1001, 8'b0000};
      va[17] = '{0, DEC,  3, 0,   {9'd255, 9'd255}, 8'b0001, 8'b1000};
      va[18] = '{0, LDC,  3, 255, {9'd255, 9'd255}, 8'b0001, 8'b1000};
      va[19] = '{0, LDR,  3, 7,   {9'd7,   9'd255}, 8'b0001, 8'b0000};
      va[20] = '{0, NOP,  2, 0,   {9'd5,   9'd11},  8'b0001, 8'b0000};

      vb[0]  = '{1, LDC,  0, 1,   {9'd0,   9'd1},   8'b1111_1110, 8'b0000_0000};
      vb[1]  = '{1, DEC,  0, 0,   {9'd255, 9'd254}, 8'b1111_1110, 8'b0000_0001};
      vb[2]  = '{1, LDR,  7, 9,   {9'd9,   9'd0},   8'b0111_1110, 8'b0000_0001};
      vb[3]  = '{1, LDC,  7, 9,   {9'd9,   9'd9},   8'b0111_1110, 8'b0000_0001};
      vb[4]  = '{1, INC,  7, 0,   {9'd9,   9'd12},  8'b0111_1110, 8'b0000_0001};
      vb[5]  = '{1, NOP,  0, 0,   {9'd255, 9'd254}, 8'b0111_1110, 8'b0000_0001};
      vb[6]  = '{1, INC,  0, 0,   {9'd0,   9'd1},   8'b0111_1110, 8'b0000_0001};
      vb[7]  = '{1, DEC,  7, 0,   {9'd9,   9'd9},   8'b0111_1110, 8'b0000_0001};

      reset = 1'b1;
      apply(0, NOP, 0, 0);
      apply(1, NOP, 0, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      push("reset_a", 0, 18'd0, 8'b0000_1111, 8'd0, 0, 0);
      push("reset_b", 1, 18'd0, 8'b1111_1111, 8'd0, 0, 0);
      check_next();
      check_next();
      reset = 1'b0;

      for (int i = 0; i < 21; i++)
         run_vec(va[i], $sformatf("vec_a%0d", i));

      walk("walk_ch3", 3, {9'd7, 9'd255}, {9'd7, 9'd255}, {9'd8, 9'd255}, {9'd8, 9'd255},
           8'b0001, 8'b0000);
      walk("walk_ch1", 1, {9'd255, 9'd253}, {9'd255, 9'd254}, {9'd255, 9'd253},
           {9'd255, 9'd254}, 8'b0001, 8'b0000);

      // Walk on ch2 {5,11} aborted by reset during W2.
      apply(0, WIN, 2, 0);
      push("abort_w0", 0, {9'd5, 9'd11}, 8'b0001, 8'b0000, 1, 0);
      push("abort_w1", 0, {9'd5, 9'd12}, 8'b0001, 8'b0000, 1, 0);
      push("abort_w2", 0, {9'd6, 9'd11}, 8'b0001, 8'b0000, 1, 0);
      push("abort_rst", 0, 18'd0, 8'b1111, 8'b0000, 0, 0);
      push("abort_post", 0, 18'd0, 8'b1111, 8'b0000, 0, 0);
      @(posedge clock);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_next();
         apply(0, NOP, 2, 0);
         if (i == 2) reset = 1'b1;
         if (i == 3) reset = 1'b0;
      end

      walk("walk_zero", 0, {9'd0, 9'd0}, {9'd0, 9'd1}, {9'd1, 9'd0}, {9'd1, 9'd1},
           8'b1111, 8'b0000);

      for (int i = 0; i < 8; i++)
         run_vec(vb[i], $sformatf("vec_b%0d", i));

      if (sb.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard: %0d expected entries left, want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
